// File: rtl/gp_pkg.sv
// Shared types and helpers for the geometry pipeline: triangle payload and z-validity test.
package gp_pkg;

    localparam int unsigned COORD_W = 32;
    localparam int unsigned COLOR_W = 4;
    localparam logic [COORD_W-1:0] FP_ONE = 32'h3f800000;

    // A vertex packs {x, y, z} with x in the top word, so element [0] is z.
    typedef logic [2:0][COORD_W-1:0] vertex_t;

    typedef struct packed {
        vertex_t              p1;
        vertex_t              p2;
        vertex_t              p3;
        logic [COLOR_W-1:0]   color;
    } triangle_t;

    localparam int unsigned TRI_W = $bits(triangle_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } disp_state_t;

    // z <= 0 (including -0) is unusable: the rasterizer divides by z.
    function automatic logic z_invalid(input logic [COORD_W-1:0] z);
        return z[COORD_W-1] || (z[COORD_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with extra-MSB pointers and registered full/empty flags.
module tri_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_nxt  = wr_ptr + PW'(do_push);
        rd_nxt  = rd_ptr + PW'(do_pop);
    end

    // Flags are computed from the next pointers so they are exact every cycle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/triangle_dispatcher.sv
// Buffers raster-space triangles, culls z<=0 ones, and issues them one at a time to the rasterizer.
module triangle_dispatcher
    import gp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        areset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0][COORD_W-1:0]     in_p1,
    input  logic [2:0][COORD_W-1:0]     in_p2,
    input  logic [2:0][COORD_W-1:0]     in_p3,
    input  logic [COLOR_W-1:0]          in_color,
    output logic                        rast_start,
    input  logic                        rast_done,
    output logic [2:0][COORD_W-1:0]     rast_p1,
    output logic [2:0][COORD_W-1:0]     rast_p2,
    output logic [2:0][COORD_W-1:0]     rast_p3,
    output logic [COLOR_W-1:0]          rast_color,
    output logic                        busy,
    output logic [CNT_W-1:0]            tri_issued,
    output logic [CNT_W-1:0]            tri_culled
);

    disp_state_t state;
    disp_state_t state_nxt;
    triangle_t   wr_tri;
    triangle_t   head_tri;
    logic [TRI_W-1:0] head_bits;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        culled;
    logic        pop;

    always_comb begin
        wr_tri.p1    = in_p1;
        wr_tri.p2    = in_p2;
        wr_tri.p3    = in_p3;
        wr_tri.color = in_color;
        push         = in_valid && in_ready;
        culled       = z_invalid(in_p1[0]) || z_invalid(in_p2[0]) || z_invalid(in_p3[0]);
        head_tri     = triangle_t'(head_bits);
    end

    tri_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRI_W)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (push && !culled),
        .din      (wr_tri),
        .pop      (pop),
        .dout     (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = !fifo_empty || (state != ST_IDLE);

    // Next-state and pop decision
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && rast_done) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (rast_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand registers load only on the pop edge so they stay stable for the whole job.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= ST_IDLE;
            rast_start <= 1'b0;
            rast_p1    <= '0;
            rast_p2    <= '0;
            rast_p3    <= '0;
            rast_color <= '0;
            tri_issued <= '0;
            tri_culled <= '0;
        end else begin
            state      <= state_nxt;
            rast_start <= (state_nxt == ST_ISSUE);
            if (pop) begin
                rast_p1    <= head_tri.p1;
                rast_p2    <= head_tri.p2;
                rast_p3    <= head_tri.p3;
                rast_color <= head_tri.color;
            end
            if (state == ST_ISSUE) begin
                tri_issued <= tri_issued + CNT_W'(1);
            end
            if (push && culled) begin
                tri_culled <= tri_culled + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher with a queue-based reference model checked every cycle.
module tb_triangle_dispatcher;
    import gp_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              areset_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0][31:0]  in_p1, in_p2, in_p3;
    logic [3:0]        in_color;
    logic              rast_start;
    logic              rast_done;
    logic [2:0][31:0]  rast_p1, rast_p2, rast_p3;
    logic [3:0]        rast_color;
    logic              busy;
    logic [CNT_W-1:0]  tri_issued;
    logic [CNT_W-1:0]  tri_culled;

    triangle_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_color   (in_color),
        .rast_start (rast_start),
        .rast_done  (rast_done),
        .rast_p1    (rast_p1),
        .rast_p2    (rast_p2),
        .rast_p3    (rast_p3),
        .rast_color (rast_color),
        .busy       (busy),
        .tri_issued (tri_issued),
        .tri_culled (tri_culled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int hold_len = 4;
    bit hold_forever = 1'b0;
    int hold_cnt = 0;

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic triangle_t mk_tri(input int i, input logic [31:0] z1, input logic [31:0] z2,
                                         input logic [31:0] z3);
        triangle_t t;
        t.p1    = {32'h41000000 + 32'(i), 32'h41200000, z1};
        t.p2    = {32'h42000000 + 32'(i), 32'h41200000, z2};
        t.p3    = {32'h41200000, 32'h42800000 + 32'(i), z3};
        t.color = 4'(i);
        return t;
    endfunction

    // Reference model: what has been accepted, what is queued, and where the current job is.
    triangle_t        mq[$];
    triangle_t        m_out;
    int               m_job;      // -1 no job, 0 start cycle, 1 waiting for done
    logic [CNT_W-1:0] m_issued;
    logic [CNT_W-1:0] m_culled;

    function automatic bit must_cull(input triangle_t t);
        logic [31:0] zs [3];
        zs[0] = t.p1[0];
        zs[1] = t.p2[0];
        zs[2] = t.p3[0];
        for (int k = 0; k < 3; k++) begin
            if (zs[k][31] == 1'b1 || zs[k][30:0] == 31'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out    = '0;
        m_job    = -1;
        m_issued = '0;
        m_culled = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge areset_n);
            if (!areset_n) begin
                model_reset();
            end else begin
                triangle_t t;
                bit take_in, take_out;
                t.p1 = in_p1; t.p2 = in_p2; t.p3 = in_p3; t.color = in_color;
                take_in  = in_valid && (mq.size() < DEPTH);
                take_out = (m_job < 0) && (mq.size() > 0) && rast_done;
                if (m_job == 0) begin
                    m_issued = m_issued + 1'b1;
                    m_job    = 1;
                end else if (m_job > 0 && rast_done) begin
                    m_job = -1;
                end
                if (take_out) begin
                    m_out = mq.pop_front();
                    m_job = 0;
                end
                if (take_in) begin
                    if (must_cull(t)) m_culled = m_culled + 1'b1;
                    else mq.push_back(t);
                end
            end
        end
    end

    // Cycle compare, mid-cycle when outputs are settled.
    initial begin
        forever begin
            triangle_t act;
            @(negedge clk);
            act.p1 = rast_p1; act.p2 = rast_p2; act.p3 = rast_p3; act.color = rast_color;
            chk("in_ready",   300'(in_ready),   300'(mq.size() < DEPTH));
            chk("rast_start", 300'(rast_start), 300'(m_job == 0));
            chk("busy",       300'(busy),       300'((mq.size() > 0) || (m_job >= 0)));
            chk("tri_issued", 300'(tri_issued), 300'(m_issued));
            chk("tri_culled", 300'(tri_culled), 300'(m_culled));
            chk("operands",   300'(act),        300'(m_out));
        end
    end

    // Rasterizer stand-in: drops done on start, raises it again after hold_len cycles.
    initial begin
        rast_done = 1'b1;
        forever begin
            @(negedge clk);
            if (!areset_n) begin
                rast_done = 1'b1;
                hold_cnt  = 0;
            end else if (rast_start) begin
                rast_done = 1'b0;
                hold_cnt  = hold_len;
            end else if (!rast_done && !hold_forever) begin
                if (hold_cnt <= 1) rast_done = 1'b1;
                else hold_cnt--;
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic push(input triangle_t t);
        int b = 0;
        in_valid = 1'b1;
        in_p1 = t.p1; in_p2 = t.p2; in_p3 = t.p3; in_color = t.color;
        while (!in_ready && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (b >= 400) begin
            chk("push_timeout", 300'(b), 300'(0));
        end else begin
            @(posedge clk);
            n_acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int b = 0;
        while ((busy || !rast_done) && b < limit) begin
            @(negedge clk);
            b++;
        end
        chk(name, 300'(b < limit), 300'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 areset_n = 1'b0;
        in_valid     = 1'b0;
        hold_forever = 1'b0;
        repeat (2) @(posedge clk);
        #2 areset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        triangle_t tb0, ta, tbb, tlast;
        int n;
        areset_n = 1'b0;
        in_valid = 1'b0;
        in_p1 = '0; in_p2 = '0; in_p3 = '0; in_color = '0;
        do_reset();

        // Reset state
        chk("rst_in_ready", 300'(in_ready), 300'(1));
        chk("rst_busy",     300'(busy),     300'(0));
        chk("rst_p1",       300'(rast_p1),  300'(0));

        // Basic issue and latency
        tb0.p1 = 96'h41200000_41200000_3f800000;
        tb0.p2 = 96'h42c80000_41200000_3f800000;
        tb0.p3 = 96'h41200000_42c80000_3f800000;
        tb0.color = 4'h5;
        push(tb0);
        n = 1;
        while (!rast_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("start_latency", 300'(n), 300'(2));
        chk("basic_p1",    300'(rast_p1),    300'(96'h41200000_41200000_3f800000));
        chk("basic_color", 300'(rast_color), 300'(4'h5));
        @(negedge clk);
        chk("basic_issued", 300'(tri_issued), 300'(1));
        wait_idle("basic_drain", 100);

        // Done protocol: 20-cycle job, second triangle queued behind it
        hold_len = 20;
        ta  = mk_tri(1, FP_ONE, FP_ONE, FP_ONE);
        tbb = mk_tri(2, FP_ONE, 32'h40000000, FP_ONE);
        push(ta);
        push(tbb);
        n = 0;
        while (!rast_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("first_start_seen", 300'(rast_start), 300'(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) chk("held_p1", 300'(rast_p1), 300'(ta.p1));
        end while (!rast_start && n < 60);
        chk("start_gap",   300'(n),       300'(22));
        chk("second_p1",   300'(rast_p1), 300'(tbb.p1));
        wait_idle("done_drain", 100);

        // Cull
        hold_len = 4;
        do_reset();
        push(mk_tri(3, FP_ONE, FP_ONE, FP_ONE));
        push(mk_tri(4, 32'hbf800000, FP_ONE, FP_ONE));
        push(mk_tri(5, FP_ONE, 32'h00000000, FP_ONE));
        push(mk_tri(6, FP_ONE, FP_ONE, 32'h80000000));
        wait_idle("cull_drain", 100);
        chk("cull_culled", 300'(tri_culled), 300'(3));
        chk("cull_issued", 300'(tri_issued), 300'(1));
        chk("cull_color",  300'(rast_color), 300'(4'd3));

        // Backpressure: first job stalls, four queue up, sixth waits
        do_reset();
        hold_forever = 1'b1;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) push(mk_tri(8 + i, FP_ONE, FP_ONE, FP_ONE));
            end
        join_none
        repeat (12) @(negedge clk);
        chk("bp_accepted", 300'(n_acc),      300'(5));
        chk("bp_in_ready", 300'(in_ready),   300'(0));
        chk("bp_issued",   300'(tri_issued), 300'(1));
        hold_len = 3;
        hold_forever = 1'b0;
        n = 0;
        while (n_acc < 6 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bp_sixth_in", 300'(n_acc), 300'(6));
        wait_idle("bp_drain", 300);
        chk("bp_issued_all", 300'(tri_issued), 300'(6));
        tlast = mk_tri(13, FP_ONE, FP_ONE, FP_ONE);
        chk("bp_last_color", 300'(rast_color), 300'(tlast.color));

        // Reset mid-job with three queued
        do_reset();
        hold_forever = 1'b1;
        for (int i = 0; i < 4; i++) push(mk_tri(i + 1, FP_ONE, FP_ONE, FP_ONE));
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 300'(busy), 300'(1));
        @(posedge clk);
        #2 areset_n = 1'b0;
        hold_forever = 1'b0;
        #1;
        chk("mid_rst_busy",     300'(busy),       300'(0));
        chk("mid_rst_in_ready", 300'(in_ready),   300'(1));
        chk("mid_rst_issued",   300'(tri_issued), 300'(0));
        chk("mid_rst_culled",   300'(tri_culled), 300'(0));
        chk("mid_rst_start",    300'(rast_start), 300'(0));
        repeat (2) @(posedge clk);
        #2 areset_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (rast_start) n++;
        end
        chk("mid_no_stale_issue", 300'(n), 300'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/triangle_dispatcher.md
Name: triangle_dispatcher

Overview:
- Upstream neighbour of rasterizer_unit.
- Accepts raster-space triangles (three float32 vertices plus a 4-bit colour) from the transform stage over a valid/ready handshake and buffers them in a small FIFO.
- Culls triangles the rasterizer cannot handle.
- Issues one triangle at a time to the rasterizer, using its start/done protocol, and holds the operands stable for the whole job.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- areset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream triangle valid.
- in_ready  out  1  FIFO can accept a triangle this cycle.
- in_p1, in_p2, in_p3  in  32 x3 each  vertex {x, y, z}, IEEE-754 single, raster coordinates.
- in_color  in  4  palette index.
- rast_start  out  1  one-cycle start pulse to the rasterizer.
- rast_done  in  1  rasterizer done level; high while idle.
- rast_p1, rast_p2, rast_p3  out  32 x3 each  operands to the rasterizer.
- rast_color  out  4  colour to the rasterizer.
- busy  out  1  FIFO non-empty or rasterizer job outstanding.
- tri_issued  out  CNT_W  count of triangles issued.
- tri_culled  out  CNT_W  count of triangles culled.

Behaviour:
Reset:
- Reset is asynchronous, active-low.
- FIFO is emptied; the state machine goes to IDLE.
- rast_start=0. rast_p* and rast_color = 0. Both counters = 0. busy=0. in_ready=1.

Input side:
- in_ready = !full.
- A push occurs when in_valid && in_ready.
- The entry is written on that clock edge and is visible to the pop side on the next cycle.
- in_valid while full is held off; no data is lost and no error is raised.

Cull rule (applied at push):
- A triangle is culled if any z has its sign bit set, or has bits [30:0]==0. This covers z <= 0 and -0; the rasterizer computes 1/z.
- A culled triangle is not written to the FIFO; tri_culled increments.
- in_ready does not depend on the cull result.

FIFO:
- DEPTH entries, each 292 bits (9x32 + 4). Read and write pointers are $clog2(DEPTH)+1 bits, with the MSB used for full/empty.
- Simultaneous push and pop while full: the pop frees the slot, but in_ready stays combinationally from the registered full flag (no fall-through). The push is therefore not taken that cycle.
- Simultaneous push and pop while neither full nor empty: both happen; occupancy is unchanged.

State machine (IDLE, ISSUE, BUSY):
- IDLE: if the FIFO is non-empty and rast_done==1, pop the head entry into the rast_p*/rast_color output registers and go to ISSUE.
- ISSUE: rast_start=1 for exactly this cycle; tri_issued increments; go to BUSY.
- BUSY: outputs are held. The first BUSY cycle always sees rast_done=0, because the rasterizer is in its START state. When rast_done==1, go to IDLE.
- Total latency from a push into an empty FIFO (rasterizer idle) to rast_start = 2 cycles: push edge, then pop in IDLE, then ISSUE.
- Back-to-back triangles: a BUSY->IDLE->ISSUE gap of 1 idle cycle is acceptable.

Operand stability:
- rast_p*/rast_color change only on the IDLE pop edge.
- They are stable from the ISSUE cycle until done returns; the rasterizer reads p* throughout its job.

Other outputs and rules:
- busy = !empty || state != IDLE.
- Counters wrap modulo 2^CNT_W.
- Reset mid-job: the state machine returns to IDLE, the FIFO is cleared, and rast_start=0. The rasterizer has its own reset.

Decomposition:
- Shared package gp_pkg:
  - triangle_t packed struct {p1[3], p2[3], p3[3], color}.
  - FP_ONE = 32'h3f800000.
  - Function z_invalid(z).
- One sub-module: tri_fifo (parameterised DEPTH and width; push/pop/full/empty/dout with registered flags).
- The state machine and cull logic live in triangle_dispatcher.

Test Plan:
- Basic issue: reset, then push one triangle with p1={41200000,41200000,3f800000} (x=y=10.0, z=1.0), p2={42c80000,41200000,3f800000}, p3={41200000,42c80000,3f800000}, color=4'h5, with rast_done held at 1. Required: rast_start pulses exactly 2 cycles after the push; rast_p1 equals the pushed p1; rast_color=5; tri_issued=1.
- Done protocol: the rasterizer model drops rast_done for 20 cycles after start. Required: no second rast_start, and rast_p* unchanged, until done rises. The next queued triangle then starts within 2 cycles.
- Cull: push triangles with z values 3f800000, bf800000 (z=-1.0), 00000000, 80000000. Required: tri_culled=3, tri_issued=1, and only the first triangle reaches rast_p*.
- Full/backpressure: hold rast_done=0 and push 6 triangles with DEPTH=4. Required: in_ready falls after the 5th accepted triangle (1 in flight, 4 queued). The 6th triangle waits. All 6 are issued in order once done toggles.
- Reset mid-job: assert areset_n=0 in BUSY with 3 entries queued. Required: busy=0, in_ready=1, counters=0, rast_start=0, and no stale issue after reset is released.
